// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Brief   : Shared instruction format constants and fetch FSM encoding.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

  // Instruction byte layout: [7] mode, [6:4] opcode, [3:2] rd, [1:0] rs
  localparam int MODE_BIT = 7;
  localparam int OPC_MSB  = 6;
  localparam int OPC_LSB  = 4;
  localparam int RD_MSB   = 3;
  localparam int RD_LSB   = 2;
  localparam int RS_MSB   = 1;
  localparam int RS_LSB   = 0;

  localparam int FSM_W = 2;
  typedef logic [FSM_W-1:0] fetch_state_t;

  localparam fetch_state_t F_IDLE = 2'd0;
  localparam fetch_state_t F_WAIT = 2'd1;
  localparam fetch_state_t F_DROP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : prefetch_fifo
// Brief  : Instruction queue holding {instr, pc} pairs; clear has priority.
// Rev    : 1.0  initial release
// ============================================================================
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [INSTR_W-1:0]      push_instr,
  input  logic [PC_W-1:0]         push_pc,
  output logic [INSTR_W-1:0]      head_instr,
  output logic [PC_W-1:0]         head_pc,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [c_aw-1:0]    r_wr_ptr;
  logic [c_aw-1:0]    r_rd_ptr;
  logic [c_aw:0]      r_count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      r_instr_mem[r_wr_ptr] <= push_instr;
      r_pc_mem[r_wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = r_instr_mem[r_rd_ptr];
  assign head_pc    = r_pc_mem[r_rd_ptr];
  assign count      = r_count;
  assign empty      = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : prefetch_unit
// Brief  : Single-outstanding instruction fetch FSM, queue and IF/ID stage.
//          Optional PREFETCH_FETCH_COUNT_EN builds the accepted-fetch counter.
// Rev    : 1.0  initial release
// ============================================================================
module prefetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic [INSTR_W-1:0]      if_id_reg,
  output logic [PC_W-1:0]         if_id_pc,
  output logic                    if_id_valid,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [15:0]             fetch_count
);

  localparam int                c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  fetch_state_t       r_state, w_state_nx;
  logic [PC_W-1:0]    r_pc, w_pc_nx;
  logic [PC_W-1:0]    r_target, w_target_nx;
  logic               w_push, w_pop, w_empty;
  logic [INSTR_W-1:0] w_head_instr;
  logic [PC_W-1:0]    w_head_pc;
  logic [INSTR_W-1:0] r_if_id_reg;
  logic [PC_W-1:0]    r_if_id_pc;
  logic               r_if_id_valid;

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_target_nx = r_target;
    w_push      = 1'b0;
    case (r_state)
      F_IDLE: begin
        if (redirect)             w_pc_nx    = redirect_pc;
        else if (q_count < c_depth) w_state_nx = F_WAIT;
      end
      F_WAIT: begin
        if (redirect) begin
          if (imem_ack) begin
            w_pc_nx    = redirect_pc;
            w_state_nx = F_IDLE;
          end else begin
            w_target_nx = redirect_pc;
            w_state_nx  = F_DROP;
          end
        end else if (imem_ack) begin
          w_push     = 1'b1;
          w_pc_nx    = r_pc + PC_W'(1);
          w_state_nx = F_IDLE;
        end
      end
      F_DROP: begin
        // The stale response must still complete before fetching the new target
        if (redirect) w_target_nx = redirect_pc;
        if (imem_ack) begin
          w_pc_nx    = redirect ? redirect_pc : r_target;
          w_state_nx = F_IDLE;
        end
      end
      default: w_state_nx = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= F_IDLE;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_target <= w_target_nx;
    end
  end

  assign imem_req  = (r_state != F_IDLE);
  assign imem_addr = r_pc;
  assign w_pop     = !redirect && !stall && !w_empty;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (w_push),
    .pop        (w_pop),
    .clear      (redirect),
    .push_instr (imem_rdata),
    .push_pc    (r_pc),
    .head_instr (w_head_instr),
    .head_pc    (w_head_pc),
    .count      (q_count),
    .empty      (w_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_id_reg   <= NOP_INSTR;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (redirect) begin
      r_if_id_reg   <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (!w_empty) begin
        r_if_id_reg   <= w_head_instr;
        r_if_id_pc    <= w_head_pc;
        r_if_id_valid <= 1'b1;
      end else begin
        r_if_id_reg   <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign if_id_reg   = r_if_id_reg;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_valid = r_if_id_valid;

`ifdef PREFETCH_FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_fetch_count <= '0;
    else if (w_push && (r_fetch_count != 16'hFFFF))
      r_fetch_count <= r_fetch_count + 16'd1;
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_prefetch_unit
// Brief  : Directed bench for prefetch_unit with a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_prefetch_unit;

  localparam int DEPTH = 4;
`ifdef PREFETCH_FETCH_COUNT_EN
  localparam int EXP_FC = 5;
`else
  localparam int EXP_FC = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn, stall, redirect, ack_en;
  logic [7:0] redirect_pc;
  logic       imem_req, imem_ack, if_id_valid;
  logic [7:0] imem_addr, imem_rdata, if_id_reg, if_id_pc;
  logic [2:0] q_count;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Memory responds in the same cycle it is asked, whenever enabled
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ 8'hA5;

  prefetch_unit #(.DEPTH(DEPTH), .PC_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_reg   (if_id_reg),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .q_count     (q_count),
    .fetch_count (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: fetch progress as a mode number, the queue as an SV queue
  int          m_mode;
  logic [7:0]  m_pc, m_tgt, m_if_reg, m_if_pc;
  logic        m_if_valid, m_ack;
  int          m_fc, m_old;
  logic [15:0] m_q[$];
  logic [15:0] m_e;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode = 0; m_pc = 8'h00; m_tgt = 8'h00;
      m_if_reg = 8'h00; m_if_pc = 8'h00; m_if_valid = 1'b0;
      m_fc = 0; m_q.delete();
    end else begin
      m_ack = (m_mode != 0) && ack_en;
      m_old = m_q.size();
      if (redirect) begin
        m_if_valid = 1'b0; m_if_reg = 8'h00;
      end else if (!stall) begin
        if (m_old > 0) begin
          m_e = m_q.pop_front();
          m_if_reg = m_e[15:8]; m_if_pc = m_e[7:0]; m_if_valid = 1'b1;
        end else begin
          m_if_reg = 8'h00; m_if_valid = 1'b0;
        end
      end
      if (m_mode == 0) begin
        if (redirect) m_pc = redirect_pc;
        else if (m_old < DEPTH) m_mode = 1;
      end else if (m_mode == 1) begin
        if (redirect && m_ack) begin m_pc = redirect_pc; m_mode = 0; end
        else if (redirect) begin m_tgt = redirect_pc; m_mode = 2; end
        else if (m_ack) begin
          m_q.push_back({m_pc ^ 8'hA5, m_pc});
          m_pc = m_pc + 8'd1;
`ifdef PREFETCH_FETCH_COUNT_EN
          if (m_fc < 65535) m_fc = m_fc + 1;
`endif
          m_mode = 0;
        end
      end else begin
        if (redirect) m_tgt = redirect_pc;
        if (m_ack) begin m_pc = m_tgt; m_mode = 0; end
      end
      if (redirect) m_q.delete();
    end
  end

  always @(negedge clk) begin
    check("imem_req",    imem_req,    (m_mode != 0));
    check("imem_addr",   imem_addr,   m_pc);
    check("if_id_valid", if_id_valid, m_if_valid);
    check("if_id_reg",   if_id_reg,   m_if_reg);
    check("if_id_pc",    if_id_pc,    m_if_pc);
    check("q_count",     q_count,     m_q.size());
    check("fetch_count", fetch_count, m_fc);
  end

  task automatic wait_req(input int budget);
    int i = 0;
    while (!imem_req && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("req_wait", imem_req, 1'b1);
  endtask

  task automatic next_valid(input int budget, output logic [7:0] r, output logic [7:0] p);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!if_id_valid && i < budget);
    check("valid_wait", if_id_valid, 1'b1);
    r = if_id_reg;
    p = if_id_pc;
  endtask

  initial begin
    logic [7:0] r, p;
    resetn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; ack_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",   imem_req,    1'b0);
    check("rst_valid", if_id_valid, 1'b0);
    check("rst_qcnt",  q_count,     3'd0);
    resetn = 1'b1;

    // First fetch and its two-edge path into IF/ID
    @(negedge clk);
    check("first_req",  imem_req,  1'b1);
    check("first_addr", imem_addr, 8'h00);
    @(negedge clk);
    check("ack_edge_valid", if_id_valid, 1'b0);
    check("ack_edge_qcnt",  q_count,     3'd1);
    @(negedge clk);
    check("seq0_valid", if_id_valid, 1'b1);
    check("seq0_reg",   if_id_reg,   8'hA5);
    check("seq0_pc",    if_id_pc,    8'h00);
    next_valid(10, r, p);
    check("seq1_reg", r, 8'hA4);
    check("seq1_pc",  p, 8'h01);
    next_valid(10, r, p);
    check("seq2_reg", r, 8'hA7);
    check("seq2_pc",  p, 8'h02);

    // Stall until the queue fills, then drain four in order
    stall = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_qcnt", q_count,   3'd4);
    check("stall_req",  imem_req,  1'b0);
    check("stall_reg",  if_id_reg, 8'hA7);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", if_id_valid, 1'b1);
      check("drain_pc",    if_id_pc,    8'(3 + i));
      check("drain_reg",   if_id_reg,   8'(3 + i) ^ 8'hA5);
    end

    // Redirect while a request is waiting; the late ack is dropped
    ack_en = 1'b0;
    wait_req(10);
    redirect = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_valid", if_id_valid, 1'b0);
    check("redir_qcnt",  q_count,     3'd0);
    check("redir_req",   imem_req,    1'b1);
    repeat (2) @(negedge clk);
    ack_en = 1'b1;
    @(negedge clk);
    check("drop_done_req", imem_req, 1'b0);
    @(negedge clk);
    check("redir_new_req",  imem_req,  1'b1);
    check("redir_new_addr", imem_addr, 8'h40);
    next_valid(10, r, p);
    check("redir_pc",  p, 8'h40);
    check("redir_reg", r, 8'hE5);

    // PC wrap from 0xFF to 0x00
    redirect = 1'b1; redirect_pc = 8'hFF;
    @(negedge clk);
    redirect = 1'b0;
    next_valid(12, r, p);
    check("wrap_pc0",  p, 8'hFF);
    check("wrap_reg0", r, 8'h5A);
    next_valid(12, r, p);
    check("wrap_pc1",  p, 8'h00);
    check("wrap_reg1", r, 8'hA5);

    // Asynchronous reset in the middle of an outstanding request
    ack_en = 1'b0;
    wait_req(10);
    #2 resetn = 1'b0;
    #1;
    check("arst_req",   imem_req,    1'b0);
    check("arst_valid", if_id_valid, 1'b0);
    check("arst_reg",   if_id_reg,   8'h00);
    check("arst_pc",    if_id_pc,    8'h00);
    check("arst_qcnt",  q_count,     3'd0);
    check("arst_fc",    fetch_count, 16'h0000);
    @(negedge clk);
    ack_en = 1'b1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_req",  imem_req,  1'b1);
    check("post_rst_addr", imem_addr, 8'h00);
    repeat (9) @(negedge clk);
    check("fetch_count5", fetch_count, EXP_FC);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
